// File: rtl/dense_pkg.sv
// Shared definitions for the dense output layer: FSM encoding, the data RAM
// memory map and the 24-bit saturation limits.
package dense_pkg;

    localparam int MAP_ADDR_W = 14;
    localparam int MAP_DATA_W = 24;

    // Memory map of the 24-bit data RAM.
    localparam logic [MAP_ADDR_W-1:0] X_BASE = 14'h0000;
    localparam logic [MAP_ADDR_W-1:0] W_BASE = 14'h1000;
    localparam logic [MAP_ADDR_W-1:0] B_BASE = 14'h2EA0;
    localparam logic [MAP_ADDR_W-1:0] Y_BASE = 14'h3000;

    // Score clamp limits (two's complement).
    localparam logic [MAP_DATA_W-1:0] SAT_MAX = 24'h7FFFFF;
    localparam logic [MAP_DATA_W-1:0] SAT_MIN = 24'h800000;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_X,
        FETCH_W,
        BIAS_RD,
        BIAS_ADD,
        WRITE_Y,
        DONE
    } dense_state_t;

endpackage

// File: rtl/dense_mac.sv
// Signed multiply-accumulate: acc += a*b when enabled, cleared by clr.
// The 48-bit product is sign-extended to the accumulator width.
module dense_mac #(
    parameter int DATA_WIDTH = 24,
    parameter int ACC_WIDTH  = 58
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [ACC_WIDTH-1:0]  o_acc
);

    localparam int PROD_W = 2 * DATA_WIDTH;

    logic signed [PROD_W-1:0] w_prod;
    logic [ACC_WIDTH-1:0]     w_prod_ext;
    logic [ACC_WIDTH-1:0]     r_acc;

    assign w_prod     = $signed(i_a) * $signed(i_b);
    assign w_prod_ext = {{(ACC_WIDTH-PROD_W){w_prod[PROD_W-1]}}, w_prod};

    // Accumulator: clear has priority over accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/dense_layer_ctrl.sv
// Fully-connected output layer sequencer. Sole master of the data RAM during
// inference: streams X and W row by row through a MAC, adds the bias after an
// arithmetic shift, saturates to 24 bits, writes Y and tracks the argmax.
module dense_layer_ctrl
    import dense_pkg::*;
#(
    parameter int N_IN          = 784,
    parameter int N_OUT         = 10,
    parameter int ADDRESS_WIDTH = 14,
    parameter int DATA_WIDTH    = 24,
    parameter int ACC_WIDTH     = 58,
    parameter int SHIFT         = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [3:0]               pred,
    output logic                     ram_en,
    output logic [3:0]               ram_we,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    input  logic [DATA_WIDTH-1:0]    ram_rdata
);

    localparam int               K_W    = $clog2(N_IN);
    localparam logic [K_W-1:0]   K_LAST = K_W'(N_IN - 1);
    localparam logic [3:0]       N_LAST = 4'(N_OUT - 1);

    dense_state_t r_state, w_next;

    logic [3:0]               r_n;
    logic [K_W-1:0]           r_k;
    logic [ADDRESS_WIDTH-1:0] r_w_ptr;
    logic [DATA_WIDTH-1:0]    r_x;
    logic [DATA_WIDTH-1:0]    r_res;
    logic [DATA_WIDTH-1:0]    r_best_val;
    logic [3:0]               r_best_idx;
    logic [3:0]               r_pred;
    logic                     r_start_q;

    logic                        w_start_acc;
    logic                        w_mac_clr;
    logic                        w_mac_en;
    logic [ACC_WIDTH-1:0]        w_acc;
    logic signed [ACC_WIDTH-1:0] w_acc_s;
    logic signed [ACC_WIDTH-1:0] w_shifted;
    logic [ACC_WIDTH:0]          w_sum;
    logic [ACC_WIDTH-DATA_WIDTH+1:0] w_hi;
    logic                        w_ovf;
    logic [DATA_WIDTH-1:0]       w_res;
    logic                        w_better;

    // A run starts only on a fresh rising edge of start seen in IDLE, so a
    // start held high (or raised during DONE) cannot launch a second run.
    assign w_start_acc = (r_state == IDLE) && start && !r_start_q;

    dense_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_mac_clr),
        .i_en  (w_mac_en),
        .i_a   (r_x),
        .i_b   (ram_rdata),
        .o_acc (w_acc)
    );

    // Floor shift, bias add one bit wider than the accumulator, then clamp:
    // the sum fits in 24 bits only if bits [ACC:DATA-1] are all equal.
    assign w_acc_s   = $signed(w_acc);
    assign w_shifted = w_acc_s >>> SHIFT;
    assign w_sum     = {w_shifted[ACC_WIDTH-1], w_shifted}
                     + {{(ACC_WIDTH+1-DATA_WIDTH){ram_rdata[DATA_WIDTH-1]}}, ram_rdata};
    assign w_hi      = w_sum[ACC_WIDTH:DATA_WIDTH-1];
    assign w_ovf     = !(&w_hi) && (|w_hi);
    assign w_res     = !w_ovf          ? w_sum[DATA_WIDTH-1:0] :
                       w_sum[ACC_WIDTH] ? DATA_WIDTH'(SAT_MIN) : DATA_WIDTH'(SAT_MAX);

    // Strict compare so ties keep the lower class index.
    assign w_better  = $signed(r_res) > $signed(r_best_val);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: one state per cycle, 2*N_IN+3 cycles per neuron.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (w_start_acc) w_next = FETCH_X;
            FETCH_X:  w_next = FETCH_W;
            FETCH_W:  w_next = (r_k == K_LAST) ? BIAS_RD : FETCH_X;
            BIAS_RD:  w_next = BIAS_ADD;
            BIAS_ADD: w_next = WRITE_Y;
            WRITE_Y:  w_next = (r_n == N_LAST) ? DONE : FETCH_X;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Outputs decoded from the state so reset drops the RAM strobes at once.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'h0;
        ram_addr  = '0;
        ram_wdata = '0;
        w_mac_clr = 1'b0;
        w_mac_en  = 1'b0;
        case (r_state)
            IDLE: begin
                w_mac_clr = 1'b1;
            end
            FETCH_X: begin
                ram_en   = 1'b1;
                ram_addr = ADDRESS_WIDTH'(X_BASE) + ADDRESS_WIDTH'(r_k);
                // rdata now holds W[n][k-1] from the previous FETCH_W.
                w_mac_en = (r_k != '0);
            end
            FETCH_W: begin
                ram_en   = 1'b1;
                ram_addr = r_w_ptr;
            end
            BIAS_RD: begin
                ram_en   = 1'b1;
                ram_addr = ADDRESS_WIDTH'(B_BASE) + ADDRESS_WIDTH'(r_n);
                w_mac_en = 1'b1;
            end
            WRITE_Y: begin
                ram_en    = 1'b1;
                ram_we    = 4'hF;
                ram_addr  = ADDRESS_WIDTH'(Y_BASE) + ADDRESS_WIDTH'(r_n);
                ram_wdata = r_res;
                w_mac_clr = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (r_state != IDLE) && (r_state != DONE);
    assign done = (r_state == DONE);
    assign pred = r_pred;

    // Counters, operand capture, result and argmax tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n        <= '0;
            r_k        <= '0;
            r_w_ptr    <= ADDRESS_WIDTH'(W_BASE);
            r_x        <= '0;
            r_res      <= '0;
            r_best_val <= DATA_WIDTH'(SAT_MIN);
            r_best_idx <= '0;
            r_pred     <= '0;
            r_start_q  <= 1'b0;
        end else begin
            r_start_q <= start;
            case (r_state)
                IDLE: begin
                    if (w_start_acc) begin
                        r_n        <= '0;
                        r_k        <= '0;
                        r_w_ptr    <= ADDRESS_WIDTH'(W_BASE);
                        r_best_val <= DATA_WIDTH'(SAT_MIN);
                        r_best_idx <= '0;
                    end
                end
                FETCH_W: begin
                    // Rows are contiguous, so the pointer simply runs on.
                    r_x     <= ram_rdata;
                    r_w_ptr <= r_w_ptr + ADDRESS_WIDTH'(1);
                    if (r_k != K_LAST) begin
                        r_k <= r_k + K_W'(1);
                    end
                end
                BIAS_ADD: begin
                    r_res <= w_res;
                end
                WRITE_Y: begin
                    if (w_better) begin
                        r_best_val <= r_res;
                        r_best_idx <= r_n;
                    end
                    if (r_n == N_LAST) begin
                        // Publish the final argmax as done rises.
                        r_pred <= w_better ? r_n : r_best_idx;
                    end else begin
                        r_n <= r_n + 4'd1;
                        r_k <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer_ctrl.sv
// Scoreboard bench for dense_layer_ctrl (default SHIFT=8). A behavioural RAM
// serves two hand-built data sets; expected Y writes and pred are queued at
// start and consumed by a monitor whenever the DUT writes or pulses done.
//
// X: X[0]=-1, X[1]=2, X[2..783]=1 (sum 783).
// Set A rows (W, B) -> Y:
//   0: W=0, B=5                 -> 5
//   1: W=256, B=0               -> 783 (0x30F)
//   2: W=0x7FFFFF, B=0x7FFFFF   -> 0x7FFFFF (sat)
//   3: W=0x800001, B=0          -> 0x800000 (sat)
//   4: W[783]=512, B=-3         -> 2-3 = 0xFFFFFF
//   5: W[0]=1, B=0              -> -1>>>8 = 0xFFFFFF (floor)
//   6: W[0]=1, B=1              -> 0
//   7: W[1]=25600, B=0          -> 51200>>8 = 200
//   8: W=0x7FFFFF, B=0          -> 0x7FFFFF (ties row 2) ; pred=2
//   9: W=0, B=5                 -> 5
// Set B: W[n][k]=256*n, B=0     -> Y[n]=783*n ; pred=9
module tb_dense_layer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [3:0]  pred;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [13:0] ram_addr;
    logic [23:0] ram_wdata;
    logic [23:0] ram_rdata = 24'h0;

    always #5 clk = ~clk;

    dense_layer_ctrl #(.SHIFT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pred      (pred),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    typedef struct packed {
        logic [13:0] a;
        logic [23:0] d;
    } wr_t;

    wr_t        exp_q[$];
    logic [3:0] pred_q[$];
    int         checks   = 0;
    int         fails    = 0;
    int         n_wr     = 0;
    int         done_cnt = 0;
    bit         bad_we   = 1'b0;
    int         ds       = 0;

    logic [23:0] y_a [10] = '{24'h000005, 24'h00030F, 24'h7FFFFF, 24'h800000, 24'hFFFFFF,
                              24'hFFFFFF, 24'h000000, 24'h0000C8, 24'h7FFFFF, 24'h000005};
    logic [23:0] y_b [10] = '{24'h000000, 24'h00030F, 24'h00061E, 24'h00092D, 24'h000C3C,
                              24'h000F4B, 24'h00125A, 24'h001569, 24'h001878, 24'h001B87};

    function automatic logic [23:0] w_word(int d, int n, int k);
        if (d == 1) return 24'(256 * n);
        case (n)
            1:       return 24'd256;
            2, 8:    return 24'h7FFFFF;
            3:       return 24'h800001;
            4:       return (k == 783) ? 24'd512 : 24'd0;
            5, 6:    return (k == 0) ? 24'd1 : 24'd0;
            7:       return (k == 1) ? 24'd25600 : 24'd0;
            default: return 24'd0;
        endcase
    endfunction

    function automatic logic [23:0] b_word(int d, int n);
        if (d == 1) return 24'd0;
        case (n)
            0, 9:    return 24'd5;
            2:       return 24'h7FFFFF;
            4:       return 24'hFFFFFD;
            6:       return 24'd1;
            default: return 24'd0;
        endcase
    endfunction

    function automatic logic [23:0] rd_word(int d, logic [13:0] a);
        int ia;
        ia = int'(a);
        if (ia < 'h1000) begin
            if (ia == 0) return 24'hFFFFFF;
            if (ia == 1) return 24'd2;
            if (ia < 784) return 24'd1;
            return 24'd0;
        end
        if (ia < 'h2EA0) return w_word(d, (ia - 'h1000) / 784, (ia - 'h1000) % 784);
        if (ia < 'h2EAA) return b_word(d, ia - 'h2EA0);
        return 24'hA5A5A5;
    endfunction

    // Synchronous-read RAM model: data valid the cycle after the read.
    always @(posedge clk) begin
        if (ram_en && ram_we == 4'h0) ram_rdata <= rd_word(ds, ram_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int d, input int cnt, input bit with_pred);
        for (int n = 0; n < cnt; n++) begin
            exp_q.push_back({14'(14'h3000 + n), (d == 1) ? y_b[n] : y_a[n]});
        end
        if (with_pred) pred_q.push_back((d == 1) ? 4'd9 : 4'd2);
    endtask

    task automatic monitor();
        wr_t e;
        logic [3:0] p;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ram_we != 4'h0) begin
                    n_wr++;
                    if (ram_we != 4'hF || !ram_en) bad_we = 1'b1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                                 ram_addr, ram_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 32'(ram_addr), 32'(e.a));
                        chk("wr_data", 32'(ram_wdata), 32'(e.d));
                    end
                end
                if (done) begin
                    done_cnt++;
                    if (pred_q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_done: pred %0d, no run expected to finish", pred);
                    end else begin
                        p = pred_q.pop_front();
                        chk("pred", 32'(pred), 32'(p));
                    end
                end
            end
        end
    endtask

    // Counts negedges after the edge that sampled start; cycle 1 is the first.
    task automatic run_wait(input bit hold, input int pulse_at, input int stop_at, output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!hold && cyc == 1) start = 1'b0;
            if (cyc == pulse_at) start = 1'b1;
            if (cyc == pulse_at + 1) start = 1'b0;
            if (done || cyc == stop_at || cyc >= 17000) break;
        end
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        start = 1'b0;
        fork
            monitor();
        join_none

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pred", 32'(pred), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Run 1: set A, a stray start pulse while busy, and start raised in DONE.
        ds = 0;
        push_exp(0, 10, 1'b1);
        start = 1'b1;
        run_wait(1'b0, 3000, -1, cyc);
        chk("run1_latency", 32'(cyc), 32'd15711);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("run1_idle_busy", 32'(busy), 32'd0);
        chk("run1_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("run1_writes", 32'(n_wr), 32'd10);
        chk("run1_done_count", 32'(done_cnt), 32'd1);
        chk("run1_we_codes", 32'(bad_we), 32'd0);

        // Run 2: abort with reset at cycle 5000; only rows 0..2 get written.
        push_exp(0, 3, 1'b0);
        start = 1'b1;
        run_wait(1'b0, -10, 5000, cyc);
        chk("abort_pre_en", 32'(ram_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_ram_en", 32'(ram_en), 32'd0);
        chk("abort_ram_we", 32'(ram_we), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_pred", 32'(pred), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("abort_writes", 32'(n_wr), 32'd13);

        // Run 3: clean restart after the abort.
        push_exp(0, 10, 1'b1);
        start = 1'b1;
        run_wait(1'b0, -10, -1, cyc);
        chk("run3_latency", 32'(cyc), 32'd15711);
        repeat (5) @(negedge clk);
        chk("run3_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("run3_writes", 32'(n_wr), 32'd23);

        // Run 4: set B with start held high for 20000 cycles -> one run only.
        ds = 1;
        push_exp(1, 10, 1'b1);
        start = 1'b1;
        run_wait(1'b1, -10, -1, cyc);
        chk("run4_latency", 32'(cyc), 32'd15711);
        repeat (20000 - cyc) @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("run4_done_count", 32'(done_cnt), 32'd3);
        chk("run4_idle_busy", 32'(busy), 32'd0);
        chk("run4_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("run4_pred_queue", 32'(pred_q.size()), 32'd0);
        chk("run4_writes", 32'(n_wr), 32'd33);
        chk("run4_pred_held", 32'(pred), 32'd9);
        chk("all_we_codes", 32'(bad_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
